otter_hazard_ctrl: RTL
======================

// Module: otter_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage OTTER (IF/DE/EX/MEM/WB). It detects RAW data hazards and
//  taken-branch/jump control hazards, and drives PC/IF-DE write enables and bubble/flush strobes.
//  It also counts stall and flush cycles. Sits beside the pipe regs; owns no datapath state.
// PARAMETERS
//  LU_STALL  1   cycles to stall a load-use consumer (1..3); state counter width = 2
//  CNT_W     16  width of saturating stall/flush performance counters
// PORTS
//  CLK            in   1      clock, all state on rising edge
//  RST            in   1      async active-high reset
//  de_rs1_addr    in   5      rs1 of instr in DE (if_pipe_reg.ir[19:15])
//  de_rs2_addr    in   5      rs2 of instr in DE
//  de_rs1_used    in   1      DE instr reads rs1
//  de_rs2_used    in   1      DE instr reads rs2
//  ex_rs1_addr    in   5      rs1 of instr in EX (operand-forward compare)
//  ex_rs2_addr    in   5      rs2 of instr in EX
//  ex_rd_addr     in   5      rd of instr in EX
//  ex_reg_write   in   1      EX instr writes rd
//  ex_mem_read    in   1      EX instr is LOAD
//  mem_rd_addr    in   5      rd of instr in MEM
//  mem_reg_write  in   1      MEM instr writes rd
//  wb_rd_addr     in   5      rd of instr in WB
//  wb_reg_write   in   1      WB instr writes rd
//  ex_redirect    in   1      taken branch / JAL / JALR resolved in EX this cycle
//  pc_write       out  1      PC update enable
//  if_de_write    out  1      IF->DE pipe reg load enable
//  if_flush       out  1      zero IF->DE pipe reg on next edge
//  de_flush       out  1      load bubble (all-zero) into DE->EX pipe reg on next edge
//  fwd_a_sel      out  2      EX srcA: 0 pipe reg, 1 MEM alu_result, 2 WB wb_data
//  fwd_b_sel      out  2      EX srcB/rs2: same encoding
//  stall_cnt      out  CNT_W  cycles with pc_write=0, saturates at all-ones
//  flush_cnt      out  CNT_W  redirect events, saturates at all-ones
// BEHAVIOUR
//  - Reset: state=RUN, stall counter=0, stall_cnt=flush_cnt=0; outputs pc_write=if_de_write=1,
//    if_flush=de_flush=0, fwd_*_sel=0. Reset mid-stall abandons the stall immediately.
//  - Match rule: hazard only if addr!=x0 AND corresponding *_used/*_reg_write is 1.
//  - FSM states RUN, LU_HOLD. Outputs combinational from state + inputs (0-cycle latency).
//  - RUN: load-use (ex_mem_read & ex_reg_write & ex_rd matches DE rs) -> pc_write=0,
//    if_de_write=0, de_flush=1; load counter=LU_STALL-1; go LU_HOLD if LU_STALL>1.
//  - LU_HOLD: same stall outputs while counter!=0; decrement; at 0 return RUN.
//  - Redirect: ex_redirect=1 -> if_flush=1, de_flush=1, pc_write=1, if_de_write=1 same cycle.
//    Overrides any stall; state->RUN and counter cleared. flush_cnt+=1.
//  - Stall and redirect together: redirect wins, stall_cnt not incremented.
//  - Forward priority (FWD_EN): MEM match (sel=1) over WB match (sel=2); x0 never forwarded.
//  - Counters: +1 per qualifying cycle, hold at 2^CNT_W-1 (no wrap).
// CONFIGURATION
//  OTTER_HAZ_FWD_EN defined: forwarding active as above; only load-use stalls.
//  OTTER_HAZ_FWD_EN undefined: fwd_*_sel tied 0, LU_STALL ignored, no LU_HOLD state. Stall
//    (pc_write=0, if_de_write=0, de_flush=1) every cycle a DE rs matches EX, MEM or WB rd
//    with reg_write=1; releases first cycle no match remains (max 3 cycles per dependency).
// TESTING
//  1 RST=1 mid-LU_HOLD -> all outputs at reset values same cycle; counters=0.
//  2 FWD_EN, LU_STALL=1: EX lw x5, DE add x6,x5,x1 -> exactly 1 cycle pc_write=0,de_flush=1;
//    stall_cnt=1; next cycle DE with lw in MEM has no stall.
//  3 FWD_EN: MEM rd=x7 wr=1, WB rd=x7 wr=1, ex_rs1=7 -> fwd_a_sel=1; rd=x0 -> fwd_a_sel=0.
//  4 ex_redirect=1 while load-use active -> if_flush=de_flush=1, pc_write=1, flush_cnt=1,
//    stall_cnt unchanged.
//  5 No FWD_EN: addi x3 in EX, DE reads x3 -> 3 stall cycles (EX,MEM,WB), then release.
//  6 CNT_W=2: 5 stall cycles -> stall_cnt sticks at 3.

Source files
------------

// File: rtl/otter_hazard_ctrl.sv
// otter_hazard_ctrl: hazard sequencer for the 5-stage OTTER pipeline.
// Detects RAW data hazards and EX-resolved redirects, and drives the PC /
// IF-DE write enables, flush strobes and operand-forward selects. It also keeps
// saturating stall/flush performance counters.
// Build option: define OTTER_HAZ_FWD_EN to enable operand forwarding. The
// pipeline then stalls only on load-use, for LU_STALL cycles. Without it, DE
// stalls while any producer is still in EX/MEM/WB.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_RUN     | normal flow; checks for load-use each cycle
// ST_LU_HOLD | extra load-use stall cycles (LU_STALL > 1), hold_cnt left
module otter_hazard_ctrl #(
    parameter int LU_STALL = 1,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       de_rs1_addr,
    input  logic [4:0]       de_rs2_addr,
    input  logic             de_rs1_used,
    input  logic             de_rs2_used,
    input  logic [4:0]       ex_rs1_addr,
    input  logic [4:0]       ex_rs2_addr,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd_addr,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd_addr,
    input  logic             wb_reg_write,
    input  logic             ex_redirect,
    output logic             pc_write,
    output logic             if_de_write,
    output logic             if_flush,
    output logic             de_flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             de1_valid;
    logic             de2_valid;
    logic             hit_ex;
    logic             stall;
    logic [1:0]       fwd_a_raw;
    logic [1:0]       fwd_b_raw;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // x0 is never a real dependency, so it is filtered out up front.
    assign de1_valid = de_rs1_used && (de_rs1_addr != 5'd0);
    assign de2_valid = de_rs2_used && (de_rs2_addr != 5'd0);
    assign hit_ex    = ex_reg_write &&
                       ((de1_valid && (de_rs1_addr == ex_rd_addr)) ||
                        (de2_valid && (de_rs2_addr == ex_rd_addr)));

`ifdef OTTER_HAZ_FWD_EN
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_LU_HOLD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] hold_cnt_q, hold_cnt_d;
    logic       load_use;

    assign load_use = ex_mem_read && hit_ex;

    // State register and load-use hold counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_RUN;
            hold_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Next state and stall request; a redirect squashes the stalled instruction.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        stall      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (load_use) begin
                    stall      = 1'b1;
                    hold_cnt_d = 2'(LU_STALL - 1);
                    if (LU_STALL > 1) state_d = ST_LU_HOLD;
                end
            end
            ST_LU_HOLD: begin
                if (hold_cnt_q != 2'd0) begin
                    stall      = 1'b1;
                    hold_cnt_d = hold_cnt_q - 2'd1;
                    if (hold_cnt_q == 2'd1) state_d = ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (ex_redirect) begin
            state_d    = ST_RUN;
            hold_cnt_d = 2'd0;
            stall      = 1'b0;
        end
    end

    // Forward selects: the younger MEM result wins over WB.
    always_comb begin
        fwd_a_raw = 2'd0;
        fwd_b_raw = 2'd0;
        if (ex_rs1_addr != 5'd0) begin
            if (mem_reg_write && (mem_rd_addr == ex_rs1_addr))     fwd_a_raw = 2'd1;
            else if (wb_reg_write && (wb_rd_addr == ex_rs1_addr))  fwd_a_raw = 2'd2;
        end
        if (ex_rs2_addr != 5'd0) begin
            if (mem_reg_write && (mem_rd_addr == ex_rs2_addr))     fwd_b_raw = 2'd1;
            else if (wb_reg_write && (wb_rd_addr == ex_rs2_addr))  fwd_b_raw = 2'd2;
        end
    end
`else
    logic hit_mem;
    logic hit_wb;
    logic unused_fwd_inputs;
    localparam int LU_STALL_UNUSED = LU_STALL;

    assign hit_mem = mem_reg_write &&
                     ((de1_valid && (de_rs1_addr == mem_rd_addr)) ||
                      (de2_valid && (de_rs2_addr == mem_rd_addr)));
    assign hit_wb  = wb_reg_write &&
                     ((de1_valid && (de_rs1_addr == wb_rd_addr)) ||
                      (de2_valid && (de_rs2_addr == wb_rd_addr)));

    // Without forwarding DE waits until the producer has left WB.
    assign stall     = !ex_redirect && (hit_ex || hit_mem || hit_wb);
    assign fwd_a_raw = 2'd0;
    assign fwd_b_raw = 2'd0;
    assign unused_fwd_inputs = ^{ex_rs1_addr, ex_rs2_addr, ex_mem_read};
`endif

    // Control outputs; held at their reset values while RST is asserted.
    always_comb begin
        pc_write    = 1'b1;
        if_de_write = 1'b1;
        if_flush    = 1'b0;
        de_flush    = 1'b0;
        fwd_a_sel   = 2'd0;
        fwd_b_sel   = 2'd0;
        if (!RST) begin
            pc_write    = !stall;
            if_de_write = !stall;
            if_flush    = ex_redirect;
            de_flush    = stall || ex_redirect;
            fwd_a_sel   = fwd_a_raw;
            fwd_b_sel   = fwd_b_raw;
        end
    end

    // Saturating performance counter next values.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != CNT_MAX))       stall_cnt_d = stall_cnt_q + 1'b1;
        if (ex_redirect && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // Performance counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
